generic_debouncer: RTL

Synthesizable input conditioner for raw mechanical inputs such as buttons and switches. It sits between the board-level input pins and the system logic. Each bit is synchronized, debounced with a per-bit stable-count filter, and normalized to active-high. The block also produces one-cycle press, release and long-press pulses for each bit.

---
 rtl/generic_debouncer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/generic_debouncer.sv
// Per-bit input conditioner: two-flop synchronizer, stable-count debounce filter,
// active-high normalization and one-cycle press/release/long-press pulses.
module generic_debouncer #(
    parameter int unsigned IW  = 1,
    parameter logic        DS  = 1'b0,
    parameter int unsigned DBC = 16,
    parameter int unsigned LP  = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] i,
    output logic [IW-1:0] o,
    output logic [IW-1:0] rise,
    output logic [IW-1:0] fall,
    output logic [IW-1:0] long
);

    localparam int unsigned CW = (DBC > 1) ? $clog2(DBC) : 1;
    localparam int unsigned LW = (LP > 0) ? $clog2(LP + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DBC - 1);

    logic [IW-1:0] s1;
    logic [IW-1:0] s2;

    // Synchronizer; the XOR folds the idle level so an active input reads as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= i ^ {IW{DS}};
            s2 <= s1;
        end
    end

    for (genvar b = 0; b < IW; b++) begin : g_bit
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          o_q;
        logic          o_nxt;
        logic          rise_q;
        logic          rise_nxt;
        logic          fall_q;
        logic          fall_nxt;

        // Any sample agreeing with the current level restarts the stable count.
        always_comb begin
            cnt_nxt  = cnt;
            o_nxt    = o_q;
            rise_nxt = 1'b0;
            fall_nxt = 1'b0;
            if (s2[b] == o_q) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_MAX) begin
                cnt_nxt  = '0;
                o_nxt    = s2[b];
                rise_nxt = s2[b];
                fall_nxt = ~s2[b];
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                o_q    <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                o_q    <= o_nxt;
                rise_q <= rise_nxt;
                fall_q <= fall_nxt;
            end
        end

        assign o[b]    = o_q;
        assign rise[b] = rise_q;
        assign fall[b] = fall_q;

        if (LP > 0) begin : g_long
            localparam logic [LW-1:0] LP_MAX = LW'(LP);
            localparam logic [LW-1:0] LP_PRE = LW'(LP - 1);

            logic [LW-1:0] lcnt;
            logic [LW-1:0] lcnt_nxt;
            logic          long_q;
            logic          long_nxt;

            // Held-time counter; a release on the same edge suppresses the pulse.
            always_comb begin
                lcnt_nxt = lcnt;
                long_nxt = 1'b0;
                if (!o_q) begin
                    lcnt_nxt = '0;
                end else begin
                    if (lcnt != LP_MAX) begin
                        lcnt_nxt = lcnt + LW'(1);
                    end
                    long_nxt = (lcnt == LP_PRE) && !fall_nxt;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lcnt   <= '0;
                    long_q <= 1'b0;
                end else begin
                    lcnt   <= lcnt_nxt;
                    long_q <= long_nxt;
                end
            end

            assign long[b] = long_q;
        end else begin : g_nolong
            assign long[b] = 1'b0;
        end
    end

endmodule
